// File: rtl/serial_shifter.sv
// Multi-cycle EX-stage shifter producing sll and sra results of one operand in parallel.
// Define SERIAL_SHIFTER_2BIT_EN to advance two bit positions per cycle (same results, fewer cycles).
module serial_shifter #(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   hyrja,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   sll_out,
    output logic [WIDTH-1:0]   sra_out
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]         state_reg, state_next;
    logic [SHAMT_W-1:0] count_reg, count_next;
    logic [WIDTH-1:0]   sll_reg, sll_next;
    logic [WIDTH-1:0]   sra_reg, sra_next;
    logic               busy_reg, done_reg;

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        sll_next   = sll_reg;
        sra_next   = sra_reg;
        case (state_reg)
            S_IDLE, S_DONE: begin
                if (start) begin
                    sll_next   = hyrja;
                    sra_next   = hyrja;
                    count_next = shamt;
                    state_next = (shamt == '0) ? S_DONE : S_SHIFT;
                end else begin
                    state_next = S_IDLE;
                end
            end
            S_SHIFT: begin
`ifdef SERIAL_SHIFTER_2BIT_EN
                if (count_reg >= SHAMT_W'(2)) begin
                    sll_next   = {sll_reg[WIDTH-3:0], 2'b00};
                    sra_next   = {{2{sra_reg[WIDTH-1]}}, sra_reg[WIDTH-1:2]};
                    count_next = count_reg - SHAMT_W'(2);
                end else begin
                    sll_next   = {sll_reg[WIDTH-2:0], 1'b0};
                    sra_next   = {sra_reg[WIDTH-1], sra_reg[WIDTH-1:1]};
                    count_next = count_reg - SHAMT_W'(1);
                end
                state_next = (count_next == '0) ? S_DONE : S_SHIFT;
`else
                sll_next   = {sll_reg[WIDTH-2:0], 1'b0};
                sra_next   = {sra_reg[WIDTH-1], sra_reg[WIDTH-1:1]};
                count_next = count_reg - SHAMT_W'(1);
                state_next = (count_reg == SHAMT_W'(1)) ? S_DONE : S_SHIFT;
`endif
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Busy/done are flopped from the next-state decode so they come straight off registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= S_IDLE;
            count_reg <= '0;
            sll_reg   <= '0;
            sra_reg   <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            sll_reg   <= sll_next;
            sra_reg   <= sra_next;
            busy_reg  <= (state_next == S_SHIFT);
            done_reg  <= (state_next == S_DONE);
        end
    end

    assign busy    = busy_reg;
    assign done    = done_reg;
    assign sll_out = sll_reg;
    assign sra_out = sra_reg;

endmodule

// File: tb/tb_serial_shifter.sv
// Self-checking bench for serial_shifter: directed table, corner sequences and random ops vs a shift model.
module tb_serial_shifter;

    logic        clock;
    logic        reset;
    logic        start;
    logic [15:0] hyrja;
    logic [3:0]  shamt;
    logic        busy;
    logic        done;
    logic [15:0] sll_out;
    logic [15:0] sra_out;

    int tests = 0;
    int fails = 0;
    int txn   = 0;

    serial_shifter #(.WIDTH(16), .SHAMT_W(4)) dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .hyrja   (hyrja),
        .shamt   (shamt),
        .busy    (busy),
        .done    (done),
        .sll_out (sll_out),
        .sra_out (sra_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [15:0] h;
        logic [3:0]  s;
        logic [15:0] exp_sll;
        logic [15:0] exp_sra;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Edges after the accepting edge until done is seen.
    function automatic int exp_lat(input logic [3:0] s);
`ifdef SERIAL_SHIFTER_2BIT_EN
        return (int'(s) + 1) / 2;
`else
        return int'(s);
`endif
    endfunction

    function automatic logic [15:0] m_sll(input logic [15:0] h, input logic [3:0] s);
        return h << s;
    endfunction

    function automatic logic [15:0] m_sra(input logic [15:0] h, input logic [3:0] s);
        logic signed [15:0] t;
        t = h;
        return t >>> s;
    endfunction

    // Called #1 after a posedge; if the DUT is in DONE this is a back-to-back accept.
    task automatic do_shift(input logic [15:0] h, input logic [3:0] s,
                            input logic [15:0] esll, input logic [15:0] esra,
                            input bit idle_after);
        int n;
        int bcnt;
        start = 1'b1;
        hyrja = h;
        shamt = s;
        @(posedge clock); #1;
        start = 1'b0;
        hyrja = 16'($urandom);
        shamt = 4'($urandom);
        n = 0;
        bcnt = 0;
        while (!done && n < 40) begin
            if (busy) bcnt++;
            @(posedge clock); #1;
            n++;
        end
        txn++;
        $display("[TB] txn %0d hyrja=0x%04h shamt=%0d sll=0x%04h sra=0x%04h latency=%0d",
                 txn, h, s, sll_out, sra_out, n);
        check("latency", n, exp_lat(s));
        check("busy_cycles", bcnt, exp_lat(s));
        check("busy_at_done", {31'd0, busy}, 32'd0);
        check("sll_out", {16'd0, sll_out}, {16'd0, esll});
        check("sra_out", {16'd0, sra_out}, {16'd0, esra});
        if (idle_after) begin
            @(posedge clock); #1;
            check("done_one_cycle", {31'd0, done}, 32'd0);
            check("sll_hold", {16'd0, sll_out}, {16'd0, esll});
            check("sra_hold", {16'd0, sra_out}, {16'd0, esra});
        end
    endtask

    initial begin
        vec_t vecs[4];
        int   dcnt;
        logic [15:0] rh;
        logic [3:0]  rs;

        vecs[0] = '{16'h8001, 4'd3,  16'h0008, 16'hF000};
        vecs[1] = '{16'h5A5A, 4'd0,  16'h5A5A, 16'h5A5A};
        vecs[2] = '{16'h7FFF, 4'd15, 16'h8000, 16'h0000};
        vecs[3] = '{16'hFFFF, 4'd15, 16'h8000, 16'hFFFF};

        reset = 1'b0;
        start = 1'b0;
        hyrja = 16'h0;
        shamt = 4'h0;
        #12;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_sll", {16'd0, sll_out}, 32'd0);
        check("reset_sra", {16'd0, sra_out}, 32'd0);
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;

        for (int i = 0; i < 4; i++)
            do_shift(vecs[i].h, vecs[i].s, vecs[i].exp_sll, vecs[i].exp_sra, 1'b1);

        // Start during SHIFT must be ignored.
        start = 1'b1; hyrja = 16'h0F00; shamt = 4'd4;
        @(posedge clock); #1;
        start = 1'b1; hyrja = 16'hFFFF; shamt = 4'd1;
        @(posedge clock); #1;
        start = 1'b0;
        dcnt = 1;
        while (!done && dcnt < 40) begin
            @(posedge clock); #1;
            dcnt++;
        end
        txn++;
        $display("[TB] txn %0d ignored-start sll=0x%04h sra=0x%04h latency=%0d", txn, sll_out, sra_out, dcnt);
        check("ign_latency", dcnt, exp_lat(4'd4));
        check("ign_sll", {16'd0, sll_out}, 32'h0000F000);
        check("ign_sra", {16'd0, sra_out}, 32'h000000F0);

        // Start in the DONE cycle is accepted back-to-back.
        do_shift(16'hC3A5, 4'd2, m_sll(16'hC3A5, 4'd2), m_sra(16'hC3A5, 4'd2), 1'b0);
        do_shift(16'h9001, 4'd5, m_sll(16'h9001, 4'd5), m_sra(16'h9001, 4'd5), 1'b0);
        do_shift(16'h1234, 4'd0, 16'h1234, 16'h1234, 1'b1);

        // Every shift amount with the same operand.
        for (int s = 0; s < 16; s++)
            do_shift(16'h8001, 4'(s), m_sll(16'h8001, 4'(s)), m_sra(16'h8001, 4'(s)), 1'b1);

        // Asynchronous reset in the middle of a shift.
        start = 1'b1; hyrja = 16'h1234; shamt = 4'd10;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (3) @(posedge clock);
        #3;
        reset = 1'b0;
        #1;
        txn++;
        $display("[TB] txn %0d reset-mid-shift busy=%0d done=%0d sll=0x%04h sra=0x%04h",
                 txn, busy, done, sll_out, sra_out);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_sll", {16'd0, sll_out}, 32'd0);
        check("abort_sra", {16'd0, sra_out}, 32'd0);
        @(posedge clock); #1;
        reset = 1'b1;
        dcnt = 0;
        repeat (20) begin
            @(posedge clock); #1;
            if (done || busy) dcnt++;
        end
        check("abort_no_done", dcnt, 0);
        check("abort_sll_idle", {16'd0, sll_out}, 32'd0);

        // Random operations with random gaps (gap 0 = back-to-back).
        for (int i = 0; i < 40; i++) begin
            rh = 16'($urandom);
            rs = 4'($urandom);
            do_shift(rh, rs, m_sll(rh, rs), m_sra(rh, rs), 1'b0);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clock); #1;
            end
        end
        repeat (3) @(posedge clock);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
